// File: rtl/uart_cmd_bridge.sv
// Command agent on the FIFO side of a UART: parses SYNC/CMD/ADDR/DATA/CHK frames,
// performs one register read or write, and answers every finished or aborted frame.
module uart_cmd_bridge #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 100000,
    parameter int         CNT_W   = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_empty,
    output logic       rd_uart,
    input  logic [7:0] rx_data,
    input  logic [7:0] rx_lsr,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] tx_data,
    output logic       reg_we,
    output logic       reg_re,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        HUNT, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, SEND
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             byte_vld, post_rst, wr_gap;
    logic             line_err, in_get, rx_state, tmo, chk_ok, cmd_wr, cmd_rd, err_inc;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       cmd_q, addr_q, data_q, chk_q, rep_cmd, rep_data, tx_byte;
    logic [2:0]       idx;
    logic             unused_lsr;

    assign unused_lsr = ^{rx_lsr[7:5], rx_lsr[0]};
    assign line_err   = |rx_lsr[4:1];
    assign in_get     = state_q inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
    assign rx_state   = (state_q == HUNT) || in_get;
    assign tmo        = in_get && !byte_vld && (cnt_q == TMO_LAST);
    assign chk_ok     = ((cmd_q ^ addr_q ^ data_q) == chk_q);
    assign cmd_wr     = chk_ok && (cmd_q == 8'h01);
    assign cmd_rd     = chk_ok && (cmd_q == 8'h02);
    assign err_inc    = (rx_state && byte_vld && line_err) || tmo
                     || ((state_q == EXEC) && !(cmd_wr || cmd_rd));

    // Strobes are gated for the first cycle out of reset so a stale state never fires.
    assign rd_uart   = rx_state && !rx_empty && !byte_vld && !reset && !post_rst;
    assign wr_uart   = (state_q == SEND) && !tx_full && !wr_gap && !reset;
    assign tx_data   = wr_uart ? tx_byte : 8'h00;
    assign reg_we    = (state_q == EXEC) && cmd_wr && !reset;
    assign reg_re    = (state_q == EXEC) && cmd_rd && !reset;
    assign reg_addr  = addr_q;
    assign reg_wdata = data_q;
    assign busy      = (state_q != HUNT);

    always_comb begin
        tx_byte = SYNC;
        case (idx)
            3'd1:    tx_byte = rep_cmd;
            3'd2:    tx_byte = addr_q;
            3'd3:    tx_byte = rep_data;
            3'd4:    tx_byte = rep_cmd ^ addr_q ^ rep_data;
            default: tx_byte = SYNC;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:     if (byte_vld && !line_err && rx_data == SYNC) state_d = GET_CMD;
            GET_CMD:  if (byte_vld) state_d = line_err ? SEND : GET_ADDR; else if (tmo) state_d = HUNT;
            GET_ADDR: if (byte_vld) state_d = line_err ? SEND : GET_DATA; else if (tmo) state_d = HUNT;
            GET_DATA: if (byte_vld) state_d = line_err ? SEND : GET_CHK;  else if (tmo) state_d = HUNT;
            GET_CHK:  if (byte_vld) state_d = line_err ? SEND : EXEC;     else if (tmo) state_d = HUNT;
            EXEC:     state_d = cmd_rd ? RD_WAIT : SEND;
            RD_WAIT:  state_d = SEND;
            SEND:     if (wr_uart && idx == 3'd4) state_d = HUNT;
            default:  state_d = HUNT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= HUNT;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            post_rst  <= 1'b1;
            byte_vld  <= 1'b0;
            wr_gap    <= 1'b0;
            cnt_q     <= '0;
            idx       <= 3'd0;
            cmd_q     <= 8'h00;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            chk_q     <= 8'h00;
            rep_cmd   <= 8'h00;
            rep_data  <= 8'h00;
            err_count <= 8'h00;
        end else begin
            post_rst <= 1'b0;
            byte_vld <= rd_uart;
            wr_gap   <= wr_uart;
            cnt_q    <= (in_get && !byte_vld && !tmo) ? cnt_q + 1'b1 : '0;

            if (state_q != SEND) idx <= 3'd0;
            else if (wr_uart)    idx <= idx + 3'd1;

            // ADDR is cleared at SYNC so an early abort reports address 00.
            if (byte_vld && !line_err) begin
                case (state_q)
                    HUNT:     if (rx_data == SYNC) addr_q <= 8'h00;
                    GET_CMD:  cmd_q  <= rx_data;
                    GET_ADDR: addr_q <= rx_data;
                    GET_DATA: data_q <= rx_data;
                    GET_CHK:  chk_q  <= rx_data;
                    default:  ;
                endcase
            end

            if (in_get && byte_vld && line_err) begin
                rep_cmd  <= 8'hEE;
                rep_data <= 8'h03;
            end

            if (state_q == EXEC) begin
                if (!chk_ok)     begin rep_cmd <= 8'hEE; rep_data <= 8'h01;   end
                else if (cmd_wr) begin rep_cmd <= 8'h81; rep_data <= data_q;  end
                else if (cmd_rd) begin rep_cmd <= 8'h82; rep_data <= data_q;  end
                else             begin rep_cmd <= 8'hEE; rep_data <= 8'h02;   end
            end

            if (state_q == RD_WAIT) rep_data <= reg_rdata;

            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: FIFO and register-bus models plus a table of
// frames with hand-computed replies, then timeout and stall/reset sequences.
module tb_uart_cmd_bridge;

    localparam int TMO = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty, rd_uart, tx_full = 1'b0, wr_uart, reg_we, reg_re, busy;
    logic [7:0] rx_data = 8'h00, rx_lsr = 8'h00, tx_data, reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00, err_count, rdata_set = 8'h00;

    uart_cmd_bridge #(.SYNC(8'hA5), .TIMEOUT(TMO), .CNT_W(7)) dut (
        .clock(clock), .reset(reset), .rx_empty(rx_empty), .rd_uart(rd_uart),
        .rx_data(rx_data), .rx_lsr(rx_lsr), .tx_full(tx_full), .wr_uart(wr_uart),
        .tx_data(tx_data), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
    );

    always #5 clock = ~clock;

    logic [7:0] rx_buf [256];
    logic [7:0] lsr_buf[256];
    logic [7:0] tx_buf [256];
    logic [7:0] wp = 8'h00, rp = 8'h00;
    int         tx_wp = 0, we_cnt = 0, re_cnt = 0, rd_viol = 0, wr_full_viol = 0;
    logic       rd_prev = 1'b0;
    logic [7:0] we_addr = 8'h00, we_data = 8'h00;

    assign rx_empty = (rp == wp);

    // Registered RX FIFO read port, TX FIFO sink and register bus.
    always @(posedge clock) begin
        rd_prev <= rd_uart;
        if (rd_uart && rd_prev) rd_viol <= rd_viol + 1;
        if (rd_uart) begin
            rx_data <= rx_buf[rp];
            rx_lsr  <= lsr_buf[rp];
            rp      <= rp + 8'h01;
        end
        if (wr_uart) begin
            tx_buf[8'(tx_wp)] <= tx_data;
            tx_wp <= tx_wp + 1;
            if (tx_full) wr_full_viol <= wr_full_viol + 1;
        end
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= reg_addr;
            we_data <= reg_wdata;
        end
        if (reg_re) begin
            re_cnt    <= re_cnt + 1;
            reg_rdata <= rdata_set;
        end
    end

    typedef struct {
        logic [63:0] frm;    // bytes left-aligned, first byte in [63:56]
        int          n;
        int          errpos; // byte carrying a line error, -1 for none
        logic [7:0]  rdata;
        logic [39:0] exp;
        int          nrep;
        int          we;
        int          re;
        int          errd;
        logic [15:0] we_ad;
    } vec_t;

    int total = 0, bad = 0, cur = 0;

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (case %0d): got %0h expected %0h", nm, cur, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] l);
        rx_buf[wp]  = d;
        lsr_buf[wp] = l;
        wp = wp + 8'h01;
    endtask

    function automatic vec_t mk(input logic [63:0] f, input int n, input int ep,
                                input logic [7:0] rd, input logic [39:0] ex, input int nr,
                                input int we, input int re, input int ed, input logic [15:0] wa);
        vec_t v;
        v.frm = f; v.n = n; v.errpos = ep; v.rdata = rd; v.exp = ex; v.nrep = nr;
        v.we = we; v.re = re; v.errd = ed; v.we_ad = wa;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int         we0, re0, t0;
        logic [7:0] e0;
        logic       ok;
        we0 = we_cnt; re0 = re_cnt; t0 = tx_wp; e0 = err_count;
        rdata_set = v.rdata;
        for (int i = 0; i < v.n; i++)
            push(v.frm[63-8*i -: 8], (i == v.errpos) ? 8'h08 : 8'h00);
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clock);
            ok = (tx_wp == t0 + v.nrep) && !busy && (rp == wp);
        end
        check("settle", 40'(ok), 40'd1);
        repeat (4) @(negedge clock);
        check("tx_count", 40'(tx_wp - t0), 40'(v.nrep));
        if (v.nrep == 5)
            check("reply", {tx_buf[8'(t0)], tx_buf[8'(t0+1)], tx_buf[8'(t0+2)],
                            tx_buf[8'(t0+3)], tx_buf[8'(t0+4)]}, v.exp);
        check("reg_we_pulses", 40'(we_cnt - we0), 40'(v.we));
        check("reg_re_pulses", 40'(re_cnt - re0), 40'(v.re));
        check("err_delta", 40'(8'(err_count - e0)), 40'(v.errd));
        if (v.we == 1) check("write_bus", 40'({we_addr, we_data}), 40'(v.we_ad));
    endtask

    vec_t       vt[8];
    int         t0, cyc;
    logic [7:0] e0;
    logic       ok;

    initial begin
        vt[0] = mk(64'hA5_01_10_3C_2D_000000, 5, -1, 8'h00, 40'hA5_81_10_3C_AD, 5, 1, 0, 0, 16'h103C);
        vt[1] = mk(64'hA5_02_20_00_22_000000, 5, -1, 8'h5A, 40'hA5_82_20_5A_F8, 5, 0, 1, 0, 16'h0000);
        vt[2] = mk(64'hA5_01_10_3C_00_000000, 5, -1, 8'h00, 40'hA5_EE_10_01_FF, 5, 0, 0, 1, 16'h0000);
        vt[3] = mk(64'hA5_07_10_3C_2B_000000, 5, -1, 8'h00, 40'hA5_EE_10_02_FC, 5, 0, 0, 1, 16'h0000);
        vt[4] = mk(64'h00_FF_13_A5_01_44_99_DC, 8, -1, 8'h00, 40'hA5_81_44_99_5C, 5, 1, 0, 0, 16'h4499);
        vt[5] = mk(64'hA5_01_10_0000000000,    3,  2, 8'h00, 40'hA5_EE_00_03_ED, 5, 0, 0, 1, 16'h0000);
        vt[6] = mk(64'h55_A5_02_30_00_32_0000, 6,  0, 8'hC3, 40'hA5_82_30_C3_71, 5, 0, 1, 1, 16'h0000);
        vt[7] = mk(64'hA5_01_10_3C_2D_000000, 5,  4, 8'h00, 40'hA5_EE_10_03_FD, 5, 0, 0, 1, 16'h0000);

        // Reset values, with a byte already waiting in the RX FIFO.
        push(8'h00, 8'h00);
        repeat (3) @(negedge clock);
        check("reset_outputs", 40'({rd_uart, wr_uart, tx_data, reg_we, reg_re, reg_addr, reg_wdata, busy, err_count}), 40'd0);
        reset = 1'b0;
        #1 check("rd_after_reset", 40'(rd_uart), 40'd0);

        for (int k = 0; k < 8; k++) begin
            cur = k;
            run_vec(vt[k]);
        end

        // A5 01 then silence: frame abandoned without a reply.
        cur = 100;
        t0 = tx_wp; e0 = err_count;
        push(8'hA5, 8'h00);
        push(8'h01, 8'h00);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clock);
            ok = busy;
        end
        check("tmo_busy_rise", 40'(ok), 40'd1);
        cyc = 0;
        while (busy && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
        check("tmo_length_ok", 40'(cyc >= TMO && cyc <= TMO + 8), 40'd1);
        check("tmo_no_tx", 40'(tx_wp - t0), 40'd0);
        check("tmo_err", 40'(8'(err_count - e0)), 40'd1);
        cur = 101;
        run_vec(vt[0]);

        // TX stall after the first reply byte, then reset in the middle of SEND.
        cur = 200;
        t0 = tx_wp;
        for (int i = 0; i < 5; i++) push(vt[0].frm[63-8*i -: 8], 8'h00);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clock);
            ok = (tx_wp == t0 + 1);
        end
        check("first_byte_out", 40'(ok), 40'd1);
        tx_full = 1'b1;
        repeat (50) @(negedge clock);
        check("stall_no_tx", 40'(tx_wp - t0), 40'd1);
        check("stall_busy", 40'(busy), 40'd1);
        tx_full = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clock);
            ok = (tx_wp == t0 + 3);
        end
        check("resume_bytes", 40'(ok), 40'd1);
        reset = 1'b1;
        check("bytes_before_reset", 40'({tx_buf[8'(t0)], tx_buf[8'(t0+1)], tx_buf[8'(t0+2)]}), 40'hA5_81_10);
        repeat (2) @(negedge clock);
        check("midsend_reset_outputs", 40'({rd_uart, wr_uart, tx_data, reg_we, reg_re, reg_addr, reg_wdata, busy, err_count}), 40'd0);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("no_bytes_after_reset", 40'(tx_wp - t0), 40'd3);
        check("idle_after_reset", 40'(busy), 40'd0);

        check("rd_spacing_violations", 40'(rd_viol), 40'd0);
        check("wr_while_full", 40'(wr_full_viol), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_bridge.md
# uart_cmd_bridge

Host-side command agent that sits on the FIFO side of the UART core, consuming received bytes through the RX FIFO read port and producing reply bytes through the TX FIFO write port. It parses fixed 5-byte command frames, performs single-byte register reads and writes on a simple local register bus, and returns an ACK or NAK frame for every completed or aborted frame. It is the user-side endpoint of the UART byte stream.

## Interface
- SYNC, 8'hA5: frame start byte for both command and reply frames.
- TIMEOUT, 100000: maximum idle cycles allowed between bytes inside a frame.
- CNT_W, 17: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx_empty  in  1  RX FIFO empty.
- rd_uart  out  1  RX FIFO read strobe, one-cycle pulse.
- rx_data  in  8  RX FIFO data, registered; valid the cycle after rd_uart.
- rx_lsr  in  8  RX FIFO status byte paired with rx_data; bits [4:1] nonzero = line error.
- tx_full  in  1  TX FIFO full.
- wr_uart  out  1  TX FIFO write strobe, one-cycle pulse.
- tx_data  out  8  TX FIFO write data, valid while wr_uart=1.
- reg_we  out  1  register write strobe, one cycle.
- reg_re  out  1  register read strobe, one cycle.
- reg_addr  out  8  register address.
- reg_wdata  out  8  register write data.
- reg_rdata  in  8  register read data, valid the cycle after reg_re.
- busy  out  1  high in any state other than HUNT.
- err_count  out  8  saturating count of discarded, aborted, or NAKed frames.

## Operation
- Command frame: SYNC, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
- CMD 8'h01 (write): reg_addr=ADDR, reg_wdata=DATA, reg_we pulse. Reply: SYNC, 8'h81, ADDR, DATA, CHK.
- CMD 8'h02 (read): reg_addr=ADDR, reg_re pulse, reg_rdata captured. Reply: SYNC, 8'h82, ADDR, RDATA, CHK. DATA byte is ignored but is included in CHK.
- NAK reply: SYNC, 8'hEE, ADDR (8'h00 if ADDR not yet received), CODE, CHK. CODE values: 8'h01 bad checksum, 8'h02 unknown CMD, 8'h03 line error.
- Reply CHK is always the XOR of reply bytes 1 through 3.
- States: HUNT -> GET_CMD -> GET_ADDR -> GET_DATA -> GET_CHK -> EXEC -> (RD_WAIT for reads) -> SEND -> HUNT.
- Byte fetch in any receive state: if !rx_empty, pulse rd_uart; the next cycle captures rx_data and rx_lsr. At most one rd_uart per 2 cycles.
- HUNT: any byte other than SYNC is dropped silently. A line-error byte is dropped and increments err_count.
- Line-error byte inside GET_CMD through GET_CHK: frame aborted; NAK 8'h03 sent; err_count increments.
- Checksum is checked first in EXEC, then CMD. Bad CHK gives NAK 8'h01; unknown CMD gives NAK 8'h02. No reg strobe fires on a NAK.
- Timeout: the counter clears on every captured byte and counts cycles spent in GET_* states. Reaching TIMEOUT returns to HUNT with no reply and increments err_count.
- SEND: 5 bytes, index 0 to 4. Each wr_uart is issued only when tx_full=0, with at least one idle cycle between writes. No rd_uart is issued during SEND or EXEC.
- err_count saturates at 8'hFF.

## Timing
- Reset values: rd_uart=0, wr_uart=0, tx_data=8'h00, reg_we=0, reg_re=0, reg_addr=8'h00, reg_wdata=8'h00, busy=0, err_count=8'h00. State goes to HUNT and the timeout counter clears.
- Reset mid-frame or mid-SEND drops the frame immediately. Unsent reply bytes are never written, and no strobe fires in the cycle after reset deasserts.
- EXEC is entered the cycle after the CHK byte is captured. reg_we or reg_re is asserted in the EXEC cycle.
- Read path: reg_rdata is sampled in RD_WAIT, one cycle after reg_re.
- The first wr_uart occurs no earlier than the cycle after EXEC (write) or after RD_WAIT (read).
- With tx_full=0 throughout, the 5 reply writes occur on alternate cycles, spanning 9 cycles.
- tx_full high stalls SEND without losing the byte index.
- Back-to-back frames: the next SYNC fetch starts the cycle after the fifth wr_uart.

## Test plan
- Write frame A5 01 10 3C 2D: reg_we pulses once with reg_addr=8'h10, reg_wdata=8'h3C. TX receives A5 81 10 3C AD.
- Read frame A5 02 20 00 22 with reg_rdata=8'h5A: reg_re pulses once. TX receives A5 82 20 5A F8.
- Frame A5 01 10 3C 00 (bad CHK): no reg_we. TX receives A5 EE 10 01 FF. err_count=1.
- Garbage bytes 00 FF 13 followed by a valid write frame: garbage ignored, one ACK sent, err_count unchanged.
- A5 01 then silence for TIMEOUT cycles: busy falls, no TX write, err_count=1. A following valid frame is answered normally.
- tx_full held high for 50 cycles during SEND, and reset asserted mid-SEND: no wr_uart while tx_full=1. After reset all outputs are at reset values and no further reply bytes are written.
